// File: rtl/pipelined_adder_pkg.sv
// Shared defaults for the pipelined adder slice.
// Holds only the default operand width and default stage count.
package pipelined_adder_pkg;
  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;
endpackage

// File: rtl/pipelined_adder_segment.sv
// adder_segment: combinational SEG-bit ripple-carry adder.
// Ports:
//   a, b  : SEG-bit operand slices
//   cin   : carry into the slice LSB
//   sum   : SEG-bit slice sum
//   cout  : carry out of the slice MSB
module adder_segment
  import pipelined_adder_pkg::*;
#(
  parameter int SEG = DEFAULT_WIDTH / DEFAULT_STAGES
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic w_c;

  // Chain of full adders; w_c walks up the slice.
  always_comb begin
    w_c = cin;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a + b + carry_in split over STAGES register
// stages, SEG = WIDTH/STAGES bits resolved per stage. Throughput 1,
// latency STAGES, valid/ready on both sides with full backpressure.
// Optional macro ADDER_SIGNED_OVF_EN adds a registered signed-overflow
// output aligned with sum.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, carry_in)
//   out_valid/out_ready : result handshake (sum, carry_out[, overflow])
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef ADDER_SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Stage k registers hold the slice-k result plus everything the later
  // stages still need: full operands and the partial sum so far.
  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_sum;
  logic [STAGES-1:0]            r_c;

  logic [STAGES-1:0]            w_vld_in, w_c_in, w_cout;
  logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_psum_in, w_sum_nxt;
  logic [STAGES-1:0][SEG-1:0]   w_slice;
  logic                         w_adv;

  // Gating with rst keeps any handshake from completing during reset.
  assign out_valid = r_vld[STAGES-1] & ~rst;
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_vld_in[k]  = in_valid;
      assign w_a_in[k]    = a;
      assign w_b_in[k]    = b;
      assign w_c_in[k]    = carry_in;
      assign w_psum_in[k] = '0;
    end else begin : g_next
      assign w_vld_in[k]  = r_vld[k-1];
      assign w_a_in[k]    = r_a[k-1];
      assign w_b_in[k]    = r_b[k-1];
      assign w_c_in[k]    = r_c[k-1];
      assign w_psum_in[k] = r_sum[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a    (w_a_in[k][k*SEG +: SEG]),
      .b    (w_b_in[k][k*SEG +: SEG]),
      .cin  (w_c_in[k]),
      .sum  (w_slice[k]),
      .cout (w_cout[k])
    );

    // Unresolved bits of the partial sum are always zero, so OR-in works.
    assign w_sum_nxt[k] = w_psum_in[k] | (WIDTH'(w_slice[k]) << (k*SEG));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_c   <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_nxt[k];
        r_c[k]   <= w_cout[k];
      end
    end
  end

  assign sum       = r_sum[STAGES-1];
  assign carry_out = r_c[STAGES-1];

  // Operand copies in the last stage are not consumed by anything.
  logic w_unused;
  assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1]};

`ifdef ADDER_SIGNED_OVF_EN
  logic r_ovf, w_ovf_nxt;

  // Operand MSBs reach the last stage with the operands themselves.
  assign w_ovf_nxt = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1]) &&
                     (w_sum_nxt[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst)        r_ovf <= 1'b0;
    else if (w_adv) r_ovf <= w_ovf_nxt;
  end

  assign overflow = r_ovf;
`endif

endmodule
